// File: rtl/alu_fault_monitor_if.sv
// Bus bundle between the fault-tolerant ALU commit stage, the fault monitor
// and the downstream writeback consumer.
interface alu_fault_monitor_if;
   logic        res_valid;
   logic [31:0] Result;
   logic        Zero;
   logic        Carry;
   logic        OverFlow;
   logic        Negative;
   logic        fault_in;
   logic        wb_valid;
   logic [31:0] wb_data;
   logic [3:0]  wb_flags;
   logic [7:0]  fault_count;
   logic        spare_sel;
   logic        perm_fault;
   logic [1:0]  mon_state;

   // Upstream side: presents committed results and the fault level.
   modport master (
      output res_valid, Result, Zero, Carry, OverFlow, Negative, fault_in,
      input  wb_valid, wb_data, wb_flags, fault_count, spare_sel, perm_fault, mon_state
   );

   // Monitor side.
   modport slave (
      input  res_valid, Result, Zero, Carry, OverFlow, Negative, fault_in,
      output wb_valid, wb_data, wb_flags, fault_count, spare_sel, perm_fault, mon_state
   );
endinterface

// File: rtl/alu_fault_monitor.sv
// ALU fault monitor: registers committed ALU results for writeback, keeps a
// leaky count of fault events and switches permanently to the spare ALU when
// the count reaches THRESH. Leak: one decrement per WINDOW clean results.
module alu_fault_monitor #(
   parameter int THRESH = 4,
   parameter int WINDOW = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_fault_monitor_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_NORMAL   = 2'b00,
      ST_DEGRADED = 2'b01,
      ST_SWITCH   = 2'b10,
      ST_SPARE    = 2'b11
   } mon_state_e;

   localparam logic [7:0]  THRESH_C = 8'(THRESH);
   localparam logic [15:0] WINDOW_C = 16'(WINDOW);

   mon_state_e  state_r;
   mon_state_e  state_s;
   logic        fault_prev_r;
   logic        fault_edge_s;
   logic [15:0] leak_cnt_r;
   logic [15:0] leak_cnt_s;
   logic [15:0] leak_inc_s;
   logic [7:0]  fault_cnt_r;
   logic [7:0]  fault_cnt_s;
   logic        wb_valid_r;
   logic [31:0] wb_data_r;
   logic [3:0]  wb_flags_r;
   logic        spare_sel_r;
   logic        perm_fault_r;

   // Fault edge detection and leaky counter update; a counted fault beats a leak expiry.
   always_comb begin
      fault_edge_s = bus.fault_in & ~fault_prev_r;
      leak_inc_s   = leak_cnt_r + 16'd1;
      fault_cnt_s  = fault_cnt_r;
      leak_cnt_s   = leak_cnt_r;
      if (fault_edge_s) begin
         leak_cnt_s = 16'd0;
         if (fault_cnt_r != 8'hFF) begin
            fault_cnt_s = fault_cnt_r + 8'd1;
         end else begin
            fault_cnt_s = fault_cnt_r;
         end
      end else if (bus.res_valid) begin
         if (leak_inc_s == WINDOW_C) begin
            leak_cnt_s = 16'd0;
            if (fault_cnt_r != 8'd0) begin
               fault_cnt_s = fault_cnt_r - 8'd1;
            end else begin
               fault_cnt_s = fault_cnt_r;
            end
         end else begin
            leak_cnt_s = leak_inc_s;
         end
      end else begin
         leak_cnt_s  = leak_cnt_r;
         fault_cnt_s = fault_cnt_r;
      end
   end

   // Next-state logic, evaluated on the updated fault count.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_NORMAL, ST_DEGRADED: begin
            if (fault_cnt_s >= THRESH_C) begin
               state_s = ST_SWITCH;
            end else if (fault_cnt_s != 8'd0) begin
               state_s = ST_DEGRADED;
            end else begin
               state_s = ST_NORMAL;
            end
         end
         ST_SWITCH: state_s = ST_SPARE;
         ST_SPARE:  state_s = ST_SPARE;
         default:   state_s = ST_NORMAL;
      endcase
   end

   // State, counters and fault history registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_NORMAL;
         fault_prev_r <= 1'b0;
         leak_cnt_r   <= 16'd0;
         fault_cnt_r  <= 8'd0;
      end else begin
         state_r      <= state_s;
         fault_prev_r <= bus.fault_in;
         leak_cnt_r   <= leak_cnt_s;
         fault_cnt_r  <= fault_cnt_s;
      end
   end

   // Writeback capture; the result that would land in the SWITCH cycle is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid_r <= 1'b0;
         wb_data_r  <= 32'd0;
         wb_flags_r <= 4'd0;
      end else if (bus.res_valid && (state_s != ST_SWITCH)) begin
         wb_valid_r <= 1'b1;
         wb_data_r  <= bus.Result;
         wb_flags_r <= {bus.Negative, bus.OverFlow, bus.Carry, bus.Zero};
      end else begin
         wb_valid_r <= 1'b0;
      end
   end

   // Sticky spare-select and permanent-fault flags, raised on SPARE entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         spare_sel_r  <= 1'b0;
         perm_fault_r <= 1'b0;
      end else if (state_s == ST_SPARE) begin
         spare_sel_r  <= 1'b1;
         perm_fault_r <= 1'b1;
      end else begin
         spare_sel_r  <= spare_sel_r;
         perm_fault_r <= perm_fault_r;
      end
   end

   assign bus.wb_valid    = wb_valid_r;
   assign bus.wb_data     = wb_data_r;
   assign bus.wb_flags    = wb_flags_r;
   assign bus.fault_count = fault_cnt_r;
   assign bus.spare_sel   = spare_sel_r;
   assign bus.perm_fault  = perm_fault_r;
   assign bus.mon_state   = state_r;

endmodule

// File: tb/tb_alu_fault_monitor.sv
// Self-checking bench for alu_fault_monitor: directed vector table, hand
// sequences for switchover/leak/reset corners, then randomized traffic
// against a behavioural model.
module tb_alu_fault_monitor;
   localparam int THRESH = 4;
   localparam int WINDOW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   alu_fault_monitor_if bus();

   alu_fault_monitor #(.THRESH(THRESH), .WINDOW(WINDOW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // behavioural model state
   bit          m_prev;
   int          m_cnt;
   int          m_leak;
   int          m_mode;   // 0 normal, 1 degraded, 2 switch, 3 spare
   bit          m_valid;
   logic [31:0] m_data;
   logic [3:0]  m_flags;

   typedef struct {
      logic        rv;
      logic [31:0] res;
      logic [3:0]  fl;
      logic        fi;
      logic        ev;
      logic [31:0] ed;
      logic [3:0]  ef;
      logic [7:0]  ec;
      logic [1:0]  es;
   } vec_t;
   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_prev = 1'b0; m_cnt = 0; m_leak = 0; m_mode = 0;
      m_valid = 1'b0; m_data = 32'd0; m_flags = 4'd0;
   endtask

   task automatic model_step(input logic rv, input logic [31:0] r, input logic [3:0] f, input logic fi);
      bit fault_event;
      fault_event = fi && !m_prev;
      m_prev = fi;
      if (fault_event) begin
         m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
         m_leak = 0;
      end else if (rv) begin
         m_leak++;
         if (m_leak == WINDOW) begin
            m_leak = 0;
            m_cnt  = (m_cnt > 0) ? m_cnt - 1 : 0;
         end
      end
      if (m_mode == 2)      m_mode = 3;
      else if (m_mode != 3) m_mode = (m_cnt >= THRESH) ? 2 : ((m_cnt > 0) ? 1 : 0);
      m_valid = rv && (m_mode != 2);
      if (m_valid) begin
         m_data  = r;
         m_flags = f;
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".wb_valid"},    32'(bus.wb_valid),    32'(m_valid));
      check({tag, ".wb_data"},     bus.wb_data,          m_data);
      check({tag, ".wb_flags"},    32'(bus.wb_flags),    32'(m_flags));
      check({tag, ".fault_count"}, 32'(bus.fault_count), 32'(m_cnt));
      check({tag, ".mon_state"},   32'(bus.mon_state),   32'(m_mode));
      check({tag, ".spare_sel"},   32'(bus.spare_sel),   32'(m_mode == 3));
      check({tag, ".perm_fault"},  32'(bus.perm_fault),  32'(m_mode == 3));
      check({tag, ".leak"},        32'(dut.leak_cnt_r),  32'(m_leak));
   endtask

   // Drive one cycle of inputs (called at posedge+1), advance model at the edge, sample at +1.
   task automatic drive(input logic rv, input logic [31:0] r, input logic [3:0] f, input logic fi);
      bus.res_valid = rv;
      bus.Result    = r;
      {bus.Negative, bus.OverFlow, bus.Carry, bus.Zero} = f;
      bus.fault_in  = fi;
      @(posedge clk);
      model_step(rv, r, f, fi);
      #1;
   endtask

   // Pulse reset mid-cycle and check outputs clear before any clock edge.
   task automatic apply_reset(input string tag);
      rst = 1'b1;
      #2;
      check({tag, ".rst_valid"}, 32'(bus.wb_valid),    32'd0);
      check({tag, ".rst_data"},  bus.wb_data,          32'd0);
      check({tag, ".rst_flags"}, 32'(bus.wb_flags),    32'd0);
      check({tag, ".rst_cnt"},   32'(bus.fault_count), 32'd0);
      check({tag, ".rst_spare"}, 32'(bus.spare_sel),   32'd0);
      check({tag, ".rst_perm"},  32'(bus.perm_fault),  32'd0);
      check({tag, ".rst_state"}, 32'(bus.mon_state),   32'd0);
      check({tag, ".rst_leak"},  32'(dut.leak_cnt_r),  32'd0);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   initial begin
      logic fi_r;
      bus.res_valid = 1'b0; bus.Result = 32'd0; bus.fault_in = 1'b0;
      bus.Zero = 1'b0; bus.Carry = 1'b0; bus.OverFlow = 1'b0; bus.Negative = 1'b0;
      model_reset();
      @(posedge clk); #1;
      apply_reset("init");

      // directed table
      vecs[0] = '{1'b1, 32'h0000_0005, 4'h0, 1'b0, 1'b1, 32'h0000_0005, 4'h0, 8'd0, 2'b00};
      vecs[1] = '{1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0005, 4'h0, 8'd1, 2'b01};
      vecs[2] = '{1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0005, 4'h0, 8'd1, 2'b01};
      vecs[3] = '{1'b0, 32'h0000_0000, 4'h0, 1'b1, 1'b0, 32'h0000_0005, 4'h0, 8'd1, 2'b01};
      vecs[4] = '{1'b0, 32'h0000_0000, 4'h0, 1'b0, 1'b0, 32'h0000_0005, 4'h0, 8'd1, 2'b01};
      vecs[5] = '{1'b1, 32'hFFFF_FFFF, 4'hA, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'hA, 8'd1, 2'b01};
      vecs[6] = '{1'b0, 32'h1234_5678, 4'hF, 1'b0, 1'b0, 32'hFFFF_FFFF, 4'hA, 8'd1, 2'b01};
      vecs[7] = '{1'b1, 32'h0000_0000, 4'h1, 1'b0, 1'b1, 32'h0000_0000, 4'h1, 8'd1, 2'b01};
      for (int i = 0; i < 8; i++) begin
         drive(vecs[i].rv, vecs[i].res, vecs[i].fl, vecs[i].fi);
         check($sformatf("vec%0d.wb_valid", i), 32'(bus.wb_valid), 32'(vecs[i].ev));
         check($sformatf("vec%0d.wb_data", i),  bus.wb_data,       vecs[i].ed);
         check($sformatf("vec%0d.wb_flags", i), 32'(bus.wb_flags), 32'(vecs[i].ef));
         check($sformatf("vec%0d.count", i),    32'(bus.fault_count), 32'(vecs[i].ec));
         check($sformatf("vec%0d.state", i),    32'(bus.mon_state),   32'(vecs[i].es));
      end

      // leak decay: two clean results so far, 62 more expire the window
      for (int i = 0; i < 62; i++) begin
         drive(1'b1, $urandom, 4'($urandom), 1'b0);
         check_model("decay");
      end
      check("decay.count", 32'(bus.fault_count), 32'd0);
      check("decay.state", 32'(bus.mon_state),   32'd0);

      // fault edge coincident with the 64th clean result
      drive(1'b0, 32'd0, 4'd0, 1'b1);
      drive(1'b0, 32'd0, 4'd0, 1'b0);
      for (int i = 0; i < 63; i++) drive(1'b1, $urandom, 4'($urandom), 1'b0);
      check("coinc.leak_before", 32'(dut.leak_cnt_r), 32'd63);
      drive(1'b1, 32'h0000_0077, 4'd0, 1'b1);
      check("coinc.count", 32'(bus.fault_count), 32'd2);
      check("coinc.leak",  32'(dut.leak_cnt_r),  32'd0);
      check("coinc.state", 32'(bus.mon_state),   32'd1);

      // switchover: four separate pulses with results every cycle
      drive(1'b0, 32'd0, 4'd0, 1'b0);
      apply_reset("pre_sw");
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'h100 + 32'(k), 4'd0, 1'b1);
         check_model("sw");
         if (k < 3) begin
            drive(1'b1, 32'h200 + 32'(k), 4'd0, 1'b0);
            check_model("sw");
         end
      end
      check("sw.state",    32'(bus.mon_state),   32'd2);
      check("sw.wb_valid", 32'(bus.wb_valid),    32'd0);
      check("sw.count",    32'(bus.fault_count), 32'd4);
      check("sw.wb_data",  bus.wb_data,          32'h0000_0202);
      drive(1'b1, 32'hABCD_0000, 4'd3, 1'b0);
      check("spare.state",    32'(bus.mon_state),  32'd3);
      check("spare.sel",      32'(bus.spare_sel),  32'd1);
      check("spare.perm",     32'(bus.perm_fault), 32'd1);
      check("spare.wb_valid", 32'(bus.wb_valid),   32'd1);
      check("spare.wb_data",  bus.wb_data,         32'hABCD_0000);
      drive(1'b0, 32'd0, 4'd0, 1'b1);
      check("spare.count5", 32'(bus.fault_count), 32'd5);
      check("spare.stay",   32'(bus.mon_state),   32'd3);
      apply_reset("in_spare");

      // reset landing in the SWITCH cycle
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 32'(k), 4'd0, 1'b1);
         drive(1'b0, 32'd0, 4'd0, 1'b0);
      end
      check("sw2.state", 32'(bus.mon_state), 32'd3);
      apply_reset("spare2");
      for (int k = 0; k < 3; k++) begin
         drive(1'b0, 32'd0, 4'd0, 1'b1);
         drive(1'b0, 32'd0, 4'd0, 1'b0);
      end
      drive(1'b1, 32'h5555_5555, 4'd0, 1'b1);
      check("sw3.state", 32'(bus.mon_state), 32'd2);
      apply_reset("in_switch");

      // fault_in already high when reset releases counts on the first clock
      bus.fault_in = 1'b1;
      apply_reset("fi_high");
      drive(1'b0, 32'd0, 4'd0, 1'b1);
      check("rel.count", 32'(bus.fault_count), 32'd1);
      check("rel.state", 32'(bus.mon_state),   32'd1);

      // randomized traffic against the model
      fi_r = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) fi_r = ~fi_r;
         if ($urandom_range(0, 999) == 0) apply_reset("rand");
         drive(1'($urandom_range(0, 1)), $urandom, 4'($urandom), fi_r);
         check_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_fault_monitor.md
ALU_FAULT_MONITOR -- requirements
Module: alu_fault_monitor

Interface
REQ-001 SHALL provide parameter THRESH, default 4: fault count that forces switchover to the spare ALU (legal 1..255).
REQ-002 SHALL provide parameter WINDOW, default 64: clean results per leak decrement (legal 2..65535).
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 res_valid  in  1  one-cycle pulse; upstream fault-tolerant ALU committed a result this cycle.
REQ-007 Result  in  32  committed ALU result.
REQ-008 Zero, Carry, OverFlow, Negative  in  1 each  committed flags.
REQ-009 fault_in  in  1  upstream fault_detected_out level; may stay high for several cycles.
REQ-010 wb_valid  out  1  one-cycle writeback strobe.
REQ-011 wb_data  out  32  registered result.
REQ-012 wb_flags  out  4  {Negative, OverFlow, Carry, Zero}, registered.
REQ-013 fault_count  out  8  leaky fault counter.
REQ-014 spare_sel  out  1  select spare ALU; sticky.
REQ-015 perm_fault  out  1  permanent-fault flag; sticky.
REQ-016 mon_state  out  2  FSM state: NORMAL=00, DEGRADED=01, SWITCH=10, SPARE=11.

Function
REQ-017 SHALL register Result/flags into wb_data/wb_flags on res_valid and assert wb_valid exactly 1 cycle later for 1 cycle, except in state SWITCH.
REQ-018 SHALL hold wb_data/wb_flags between strobes.
REQ-019 SHALL count a fault only on a fault_in rising edge (0 in the previous cycle, 1 now); a held level counts once.
REQ-020 fault_count SHALL increment by 1 per counted fault and saturate at 255.
REQ-021 SHALL keep a 16-bit leak counter, incremented on each res_valid cycle with no counted fault.
REQ-022 On reaching WINDOW, the leak counter SHALL clear; in the same cycle fault_count SHALL decrement by 1, not below 0.
REQ-023 A counted fault SHALL clear the leak counter; if it coincides with leak expiry, the fault wins: count increments, no decrement.
REQ-024 FSM NORMAL -> DEGRADED when fault_count becomes nonzero.
REQ-025 FSM DEGRADED -> NORMAL when fault_count decays to 0.
REQ-026 FSM NORMAL/DEGRADED -> SWITCH on the cycle the updated fault_count >= THRESH.
REQ-027 SWITCH SHALL last exactly 1 cycle: wb_valid forced 0, in-flight result dropped.
REQ-028 FSM SWITCH -> SPARE unconditionally; spare_sel and perm_fault SHALL rise on SPARE entry.
REQ-029 SPARE SHALL be terminal until reset; writeback resumes; faults still counted and leaked; no state change.
REQ-030 mon_state SHALL reflect the registered state.

Reset
REQ-031 rst high SHALL asynchronously clear all of the following, at any point including mid-SWITCH: wb_valid, wb_data, wb_flags, fault_count, leak counter, fault_in history, spare_sel, perm_fault; mon_state SHALL be NORMAL.
REQ-032 After rst deasserts, a fault_in already high SHALL count as a rising edge on the first clock.

Verification
REQ-033 Scenario: res_valid with Result=0x0000_0005, Zero=0 -> next cycle wb_valid=1, wb_data=0x5, wb_flags=0000.
REQ-034 Scenario: fault_in high 3 cycles, then low -> fault_count=1, mon_state=01.
REQ-035 Scenario: 4 separate fault_in pulses -> fault_count=4, one SWITCH cycle with wb_valid=0, then mon_state=11, spare_sel=1, perm_fault=1.
REQ-036 Scenario: one fault, then 64 clean res_valid pulses -> fault_count=0, mon_state=00.
REQ-037 Scenario: fault_in edge in the same cycle as the 64th clean count -> fault_count +1, leak counter=0.
REQ-038 Scenario: rst pulse during SPARE or SWITCH -> all outputs 0, mon_state=00 immediately, without waiting for clk.
